// File: rtl/dmem_ctrl_pkg.sv
// Shared constants and types for the dmem_ctrl data-memory controller.
// Sub-word support in the controller is selected by DMEM_SUBWORD_EN.
package dmem_ctrl_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int BUS_ADDR_W = ADDR_W - 2;
  localparam int BE_W       = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Access size codes; 2'b11 behaves like a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/dmem_ctrl_if.sv
// CPU-side request/response and external data-bus signals of dmem_ctrl.
// master = the controller itself, slave = the CPU pipeline plus memory bus around it.
interface dmem_ctrl_if;
  import dmem_ctrl_pkg::*;

  logic                  req;
  logic                  we;
  logic [1:0]            size;
  logic                  sext;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  stall;
  logic                  done;
  logic                  err;
  logic [DATA_W-1:0]     rdata;
  logic                  bus_req;
  logic                  bus_we;
  logic [BUS_ADDR_W-1:0] bus_addr;
  logic [BE_W-1:0]       bus_be;
  logic [DATA_W-1:0]     bus_wdata;
  logic                  bus_ack;
  logic [DATA_W-1:0]     bus_rdata;

  modport master (
    input  req, we, size, sext, addr, wdata, bus_ack, bus_rdata,
    output stall, done, err, rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport slave (
    output req, we, size, sext, addr, wdata, bus_ack, bus_rdata,
    input  stall, done, err, rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

endinterface

// File: rtl/dmem_lane.sv
// Byte-lane steering for sub-word accesses: store replication / byte enables
// and load lane extraction with sign or zero extension. Purely combinational.
module dmem_lane
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]        i_st_size,
  input  logic [1:0]        i_st_addr_lo,
  input  logic [DATA_W-1:0] i_st_wdata,
  output logic [BE_W-1:0]   o_st_be,
  output logic [DATA_W-1:0] o_st_wdata,
  input  logic [1:0]        i_ld_size,
  input  logic [1:0]        i_ld_addr_lo,
  input  logic              i_ld_sext,
  input  logic [DATA_W-1:0] i_ld_word,
  output logic [DATA_W-1:0] o_ld_data
);

  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  assign w_ld_byte = i_ld_word[{i_ld_addr_lo, 3'b000} +: 8];
  assign w_ld_half = i_ld_word[{i_ld_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_st_be    = {BE_W{1'b1}};
    o_st_wdata = i_st_wdata;
    case (i_st_size)
      SZ_BYTE: begin
        o_st_be    = 4'b0001 << i_st_addr_lo;
        o_st_wdata = {4{i_st_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_st_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_st_wdata = {2{i_st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_ld_data = i_ld_word;
    case (i_ld_size)
      SZ_BYTE: o_ld_data = {{24{i_ld_sext & w_ld_byte[7]}}, w_ld_byte};
      SZ_HALF: o_ld_data = {{16{i_ld_sext & w_ld_half[15]}}, w_ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: alignment check, lane steering and req/ack bus cycle.
// Define DMEM_SUBWORD_EN for byte/half accesses; otherwise every access is a word.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst_n,
  dmem_ctrl_if.master bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_done;
  logic                  r_err;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_bus_req;
  logic                  r_bus_we;
  logic [BUS_ADDR_W-1:0] r_bus_addr;
  logic [BE_W-1:0]       r_bus_be;
  logic [DATA_W-1:0]     r_bus_wdata;

  logic                  w_misaligned;
  logic [BE_W-1:0]       w_st_be;
  logic [DATA_W-1:0]     w_st_wdata;
  logic [DATA_W-1:0]     w_ld_data;

`ifdef DMEM_SUBWORD_EN
  logic [1:0] r_size;
  logic [1:0] r_addr_lo;
  logic       r_sext;

  assign w_misaligned = (bus.size == SZ_BYTE) ? 1'b0 :
                        (bus.size == SZ_HALF) ? bus.addr[0] :
                                                (bus.addr[1:0] != 2'b00);

  // Store side steers the live request; load side uses the request latched at accept.
  dmem_lane u_lane (
    .i_st_size    (bus.size),
    .i_st_addr_lo (bus.addr[1:0]),
    .i_st_wdata   (bus.wdata),
    .o_st_be      (w_st_be),
    .o_st_wdata   (w_st_wdata),
    .i_ld_size    (r_size),
    .i_ld_addr_lo (r_addr_lo),
    .i_ld_sext    (r_sext),
    .i_ld_word    (bus.bus_rdata),
    .o_ld_data    (w_ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_size    <= SZ_WORD;
      r_addr_lo <= 2'b00;
      r_sext    <= 1'b0;
    end else if (r_state == ST_IDLE && bus.req) begin
      r_size    <= bus.size;
      r_addr_lo <= bus.addr[1:0];
      r_sext    <= bus.sext;
    end
  end
`else
  assign w_misaligned = (bus.addr[1:0] != 2'b00);
  assign w_st_be      = {BE_W{1'b1}};
  assign w_st_wdata   = bus.wdata;
  assign w_ld_data    = bus.bus_rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= '0;
      r_bus_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.req) begin
            if (w_misaligned) begin
              r_state <= ST_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state     <= ST_BUS;
              r_cnt       <= '0;
              r_bus_req   <= 1'b1;
              r_bus_we    <= bus.we;
              r_bus_addr  <= bus.addr[ADDR_W-1:2];
              r_bus_be    <= w_st_be;
              r_bus_wdata <= w_st_wdata;
            end
          end
        end
        ST_BUS: begin
          // An ack in the same cycle as the timeout still completes the access.
          if (bus.bus_ack) begin
            r_state   <= ST_DONE;
            r_bus_req <= 1'b0;
            r_done    <= 1'b1;
            if (!r_bus_we) r_rdata <= w_ld_data;
          end else if (TIMEOUT != 0 && r_cnt == CNT_LAST) begin
            r_state   <= ST_ERR;
            r_bus_req <= 1'b0;
            r_err     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.stall     = (r_state == ST_IDLE && bus.req) || (r_state == ST_BUS);
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.rdata     = r_rdata;
  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_be    = r_bus_be;
  assign bus.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, async-reset sequence,
// then randomized accesses checked against a byte-arithmetic reference model.
module tb_dmem_ctrl;

  localparam int TO = 4;
`ifdef DMEM_SUBWORD_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] last_load;

  always #5 clk = ~clk;

  dmem_ctrl_if ifc ();

  dmem_ctrl #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  // Observations collected by run_txn.
  int          ob_done, ob_err, ob_breq;
  bit          ob_stall_ok, ob_const_ok, ob_idle;
  logic [31:0] ob_rdata, ob_wdata;
  logic [3:0]  ob_be;
  logic [29:0] ob_baddr;
  logic        ob_bwe;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack;
    logic [31:0] word;
    int          exp_done;
    int          exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [29:0] exp_baddr;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Presents one request starting at the next rising edge and observes it to completion.
  task automatic run_txn(input logic t_we, input logic [1:0] t_size, input logic t_sext,
                         input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         input int t_ack, input logic [31:0] t_word, input bit t_spur);
    ob_done = 0; ob_err = 0; ob_breq = 0;
    ob_stall_ok = 1'b1; ob_const_ok = 1'b1; ob_idle = 1'b0;
    ob_rdata = '0; ob_wdata = '0; ob_be = '0; ob_baddr = '0; ob_bwe = 1'b0;
    @(posedge clk); #1;
    ifc.req = 1'b1; ifc.we = t_we; ifc.size = t_size; ifc.sext = t_sext;
    ifc.addr = t_addr; ifc.wdata = t_wdata;
    ifc.bus_ack = t_spur; ifc.bus_rdata = $urandom;
    @(negedge clk);
    if (ifc.stall !== 1'b1) ob_stall_ok = 1'b0;
    for (int c = 1; c <= 40 && ob_done == 0 && ob_err == 0; c++) begin
      @(posedge clk); #1;
      ifc.bus_ack   = (c == t_ack);
      ifc.bus_rdata = (c == t_ack) ? t_word : $urandom;
      @(negedge clk);
      if (ifc.done === 1'b1) begin ob_done = c; ob_rdata = ifc.rdata; end
      if (ifc.err === 1'b1) ob_err = c;
      if (ifc.bus_req === 1'b1) begin
        if (ob_breq == 0) begin
          ob_be = ifc.bus_be; ob_wdata = ifc.bus_wdata;
          ob_baddr = ifc.bus_addr; ob_bwe = ifc.bus_we;
        end else if (ob_be !== ifc.bus_be || ob_wdata !== ifc.bus_wdata ||
                     ob_baddr !== ifc.bus_addr || ob_bwe !== ifc.bus_we) begin
          ob_const_ok = 1'b0;
        end
        ob_breq++;
      end
      if (ifc.stall !== !(ifc.done === 1'b1 || ifc.err === 1'b1)) ob_stall_ok = 1'b0;
    end
    @(posedge clk); #1;
    ifc.req = 1'b0; ifc.bus_ack = 1'b0;
    @(negedge clk);
    ob_idle = (ifc.stall === 1'b0) && (ifc.bus_req === 1'b0) &&
              (ifc.done === 1'b0) && (ifc.err === 1'b0);
  endtask

  task automatic compare(input string tag, input logic we, input int e_done, input int e_err,
                         input logic [31:0] e_rdata, input logic [3:0] e_be,
                         input logic [31:0] e_wdata, input logic [29:0] e_baddr);
    int e_breq;
    e_breq = (e_done != 0) ? e_done - 1 : e_err - 1;
    $display("[TB] %s we=%0b done@%0d err@%0d rdata=%08h be=%04b", tag, we, ob_done, ob_err,
             ob_rdata, ob_be);
    check({tag, "/done_cycle"}, 64'(ob_done), 64'(e_done));
    check({tag, "/err_cycle"}, 64'(ob_err), 64'(e_err));
    check({tag, "/bus_req_cycles"}, 64'(ob_breq), 64'(e_breq));
    check({tag, "/stall_pattern"}, 64'(ob_stall_ok), 64'd1);
    check({tag, "/idle_after"}, 64'(ob_idle), 64'd1);
    if (e_done != 0) check({tag, "/rdata"}, 64'(ob_rdata), 64'(e_rdata));
    if (e_breq > 0) begin
      check({tag, "/bus_be"}, 64'(ob_be), 64'(e_be));
      check({tag, "/bus_addr"}, 64'(ob_baddr), 64'(e_baddr));
      check({tag, "/bus_we"}, 64'(ob_bwe), 64'(we));
      check({tag, "/bus_stable"}, 64'(ob_const_ok), 64'd1);
      if (we) check({tag, "/bus_wdata"}, 64'(ob_wdata), 64'(e_wdata));
    end
  endtask

  // Reference behaviour expressed as byte arithmetic on the access width.
  function automatic void model(input logic we, input logic [1:0] size, input logic sext,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int ack, input logic [31:0] word,
                                output int e_done, output int e_err, output logic [31:0] e_rdata,
                                output logic [3:0] e_be, output logic [31:0] e_wdata);
    int nbytes, off;
    logic [31:0] mask, v;
    nbytes = !SUB ? 4 : (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr % 32'd4);
    e_done = 0; e_err = 0;
    if (off % nbytes != 0) e_err = 1;
    else if (ack >= 1 && (TO == 0 || ack <= TO)) e_done = ack + 1;
    else e_err = TO + 1;
    e_be = 4'(((1 << nbytes) - 1) << off);
    e_wdata = '0;
    for (int i = 0; i < 4; i++) e_wdata[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    v = (word >> (8 * off)) & mask;
    if (sext && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
    e_rdata = we ? last_load : v;
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          e_done, e_err;
    logic [31:0] e_rdata, e_wdata, t_addr, t_wdata, t_word;
    logic [3:0]  e_be;
    logic [1:0]  t_size;
    logic        t_we, t_sext;
    int          t_ack;

    //          we    size  sext  addr          wdata         ack word          done             err              rdata          be      wdata         baddr
    vecs[0] = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,        1, 32'hDEADBEEF, 2,               0,               32'hDEADBEEF, 4'hF,   32'h0,        30'h40};
    vecs[1] = '{1'b1, 2'd0, 1'b0, 32'h0000_0203, 32'h0000_00A5, 2, 32'h0,       SUB ? 3 : 0,     SUB ? 0 : 1,     32'hDEADBEEF, 4'b1000, 32'hA5A5A5A5, 30'h80};
    vecs[2] = '{1'b0, 2'd0, 1'b1, 32'h0000_0002, 32'h0,        1, 32'h0080_0000, SUB ? 2 : 0,    SUB ? 0 : 1,     32'hFFFFFF80, 4'b0100, 32'h0,       30'h0};
    vecs[3] = '{1'b0, 2'd0, 1'b0, 32'h0000_0002, 32'h0,        1, 32'h0080_0000, SUB ? 2 : 0,    SUB ? 0 : 1,     32'h00000080, 4'b0100, 32'h0,       30'h0};
    vecs[4] = '{1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0,        1, 32'h1111_1111, 0,              1,               32'h0,        4'hF,   32'h0,        30'h40};
    vecs[5] = '{1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0,        0, 32'h0,         0,              TO + 1,          32'h0,        4'hF,   32'h0,        30'hC0};
    vecs[6] = '{1'b0, 2'd3, 1'b0, 32'h0000_0304, 32'h0,        TO, 32'h12345678, TO + 1,         0,               32'h12345678, 4'hF,   32'h0,        30'hC1};
    vecs[7] = '{1'b1, 2'd1, 1'b0, 32'h0000_0402, 32'h0000_BEEF, 1, 32'h0,        SUB ? 2 : 0,    SUB ? 0 : 1,     32'h12345678, 4'b1100, 32'hBEEFBEEF, 30'h100};
    vecs[8] = '{1'b0, 2'd1, 1'b1, 32'h0000_0406, 32'h0,        3, 32'h8001_0000, SUB ? 4 : 0,    SUB ? 0 : 1,     32'hFFFF8001, 4'b1100, 32'h0,       30'h101};
    vecs[9] = '{1'b1, 2'd2, 1'b0, 32'h0000_0408, 32'h11223344, 1, 32'h0,         2,              0,               SUB ? 32'hFFFF8001 : 32'h12345678, 4'hF, 32'h11223344, 30'h102};

    ifc.req = 1'b0; ifc.we = 1'b0; ifc.size = 2'd0; ifc.sext = 1'b0;
    ifc.addr = '0; ifc.wdata = '0; ifc.bus_ack = 1'b0; ifc.bus_rdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset/stall_done_err_req", 64'({ifc.stall, ifc.done, ifc.err, ifc.bus_req, ifc.bus_we}), 64'd0);
    check("reset/rdata", 64'(ifc.rdata), 64'd0);
    check("reset/bus_addr_be", 64'({ifc.bus_addr, ifc.bus_be}), 64'd0);
    check("reset/bus_wdata", 64'(ifc.bus_wdata), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].we, vecs[i].size, vecs[i].sext, vecs[i].addr, vecs[i].wdata,
              vecs[i].ack, vecs[i].word, 1'b0);
      compare($sformatf("vec%0d", i), vecs[i].we, vecs[i].exp_done, vecs[i].exp_err,
              vecs[i].exp_rdata, vecs[i].exp_be, vecs[i].exp_wdata, vecs[i].exp_baddr);
    end

    // Asynchronous reset while the bus cycle is outstanding.
    @(posedge clk); #1;
    ifc.req = 1'b1; ifc.we = 1'b0; ifc.size = 2'd2; ifc.addr = 32'h500; ifc.bus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstmid/bus_req_before", 64'(ifc.bus_req), 64'd1);
    ifc.req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstmid/bus_req_dropped", 64'(ifc.bus_req), 64'd0);
    check("rstmid/no_done_err", 64'({ifc.done, ifc.err}), 64'd0);
    check("rstmid/stall", 64'(ifc.stall), 64'd0);
    check("rstmid/rdata_cleared", 64'(ifc.rdata), 64'd0);
    @(negedge clk);
    check("rstmid/held", 64'({ifc.bus_req, ifc.done, ifc.err}), 64'd0);
    rst_n = 1'b1;
    run_txn(1'b0, 2'd2, 1'b0, 32'h504, 32'h0, 2, 32'hCAFEF00D, 1'b0);
    compare("after_reset", 1'b0, 3, 0, 32'hCAFEF00D, 4'hF, 32'h0, 30'h141);
    last_load = 32'hCAFEF00D;

    for (int n = 0; n < 200; n++) begin
      t_we    = 1'($urandom_range(0, 1));
      t_size  = 2'($urandom_range(0, 3));
      t_sext  = 1'($urandom_range(0, 1));
      t_addr  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (t_size == 2'd1 || !SUB) t_addr[0] = 1'b0;
        if (t_size[1] || !SUB) t_addr[1:0] = 2'b00;
      end
      t_wdata = $urandom;
      t_word  = $urandom;
      t_ack   = $urandom_range(0, 6);
      model(t_we, t_size, t_sext, t_addr, t_wdata, t_ack, t_word, e_done, e_err, e_rdata, e_be, e_wdata);
      run_txn(t_we, t_size, t_sext, t_addr, t_wdata, t_ack, t_word, 1'($urandom_range(0, 1)));
      compare($sformatf("rnd%0d", n), t_we, e_done, e_err, e_rdata, e_be, e_wdata, t_addr[31:2]);
      if (e_done != 0 && !t_we) last_load = e_rdata;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
